id_ctrl_pipe: RTL and testbench
===============================

Name: id_ctrl_pipe

Overview:
- Parametrised successor to the decode-stage control generator for the 5-stage MIPS pipeline.
- Decodes the IF/ID opcode into WB/MEM/EX control bundles and registers them into the ID/EX control slice.
- Adds ADDI and explicit NOP decode, in_valid qualification, flush, load-use hazard detection with bubble insertion, a sticky illegal-opcode flag, and saturating event counters.
- Sits between the IF/ID register and the ID/EX register; its hazard_stall output drives PC/IF-ID write enables.

Parameters:
OPCODE_W, 6, opcode field width
REG_W, 5, register-specifier width
CNT_W, 16, width of stall_count and illegal_count (saturating)
EN_ADDI, 1, 1 = decode ADDI (6'b001000); 0 = treat it as illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  IF/ID holds a real instruction
opcode  in  OPCODE_W  IF/ID opcode field
id_rs  in  REG_W  IF/ID rs field
id_rt  in  REG_W  IF/ID rt field
ex_rt  in  REG_W  rt of the instruction currently in ID/EX
flush  in  1  branch-taken squash of the ID instruction
wb  out  2  [1]=RegWrite, [0]=MemToReg (registered)
mem  out  3  [2]=Branch, [1]=MemRead, [0]=MemWrite (registered)
ex  out  4  [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc (registered)
ctrl_valid  out  1  ID/EX slice holds a real instruction (registered)
hazard_stall  out  1  combinational: hold PC and IF/ID this cycle
illegal_flag  out  1  sticky: an unknown opcode was decoded
stall_count  out  CNT_W  saturating count of load-use bubbles
illegal_count  out  CNT_W  saturating count of illegal opcodes

Behaviour:
- Reset (async, on rst high): wb=0, mem=0, ex=0, ctrl_valid=0, illegal_flag=0, both counters=0. hazard_stall evaluates to 0, since ctrl_valid=0.
- Decode table (wb/mem/ex):
  - RTYPE 000000 -> 10/000/1100
  - LW 100011 -> 11/010/0001
  - SW 101011 -> 00/001/0001
  - BEQ 000100 -> 00/100/0010
  - ADDI 001000 (EN_ADDI=1) -> 10/000/0001
  - NOP 100000 -> 00/000/0000, legal
  - any other opcode -> 00/000/0000, illegal
- uses_rt = RTYPE | SW | BEQ.
- hazard_stall = ctrl_valid & mem[1] & (ex_rt != 0) & in_valid & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- Each rising edge, priority order:
  1. flush=1 -> bundle 0, ctrl_valid=0. No counter or flag update.
  2. hazard_stall=1 -> bubble: bundle 0, ctrl_valid=0, stall_count+1 (saturating). The instruction stays in IF/ID and is re-decoded next cycle.
  3. in_valid=0 -> bundle 0, ctrl_valid=0.
  4. Otherwise -> bundle = decode(opcode), ctrl_valid=1. If the opcode is illegal: illegal_flag<=1 and illegal_count+1 (saturating). An illegal opcode still produces an all-zero bundle with ctrl_valid=1, so it retires as a NOP.
- Latency: 1 cycle from opcode to bundle.
- A load-use stall lasts exactly 1 cycle, because the bubble clears mem[1].
- Counters hold at all-ones and never wrap.
- illegal_flag clears only on rst.
- rst asserted mid-stream overrides all other inputs immediately. The first post-reset edge decodes normally.
- No $display or simulation-only output in synthesizable RTL.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - opcode localparams: RTYPE, LW, SW, BEQ, ADDI, NOP
  - field-position constants for the wb/mem/ex bundles
  - bundle widths: 2, 3, 4
- One natural sub-module: `ctrl_decode_rom`. It is a combinational function of opcode and EN_ADDI with outputs wb, mem, ex, uses_rt, illegal.
- Hazard logic, the ID/EX control register and the counters stay in the top module.

Test Plan:
- Reset mid-stream: assert rst asynchronously between edges while LW is registered -> all outputs 0 without waiting for a clock edge; release rst, then RTYPE -> wb=10, mem=000, ex=1100, ctrl_valid=1 one cycle later.
- Decode sweep: LW, SW, BEQ, ADDI, NOP back-to-back with in_valid=1 -> 11/010/0001, 00/001/0001, 00/100/0010, 10/000/0001, 00/000/0000; illegal_flag stays 0.
- Load-use hazard: LW with ex_rt=5, then RTYPE with id_rt=5 -> hazard_stall=1 for one cycle, a zero bubble is registered, stall_count=1; the next cycle decodes RTYPE. Same sequence with ex_rt=0 -> no stall.
- Flush priority: flush=1 together with a hazard condition -> bundle 0, ctrl_valid=0, stall_count unchanged.
- Illegal opcode: opcode 111111 -> bundle 0, ctrl_valid=1, illegal_flag=1, illegal_count=1; with EN_ADDI=0, ADDI is also counted as illegal.
- Saturation: with CNT_W=2, apply 5 illegal opcodes -> illegal_count ends at 3.

Source files
------------

// File: rtl/id_ctrl_pipe_pkg.sv
// Shared decode-stage definitions: opcodes, bundle widths and control field positions.
package mips_ctrl_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_NOP   = 6'b100000;

    localparam int unsigned WB_W  = 2;
    localparam int unsigned MEM_W = 3;
    localparam int unsigned EX_W  = 4;

    localparam int unsigned WB_REGWRITE  = 1;
    localparam int unsigned WB_MEMTOREG  = 0;
    localparam int unsigned MEM_BRANCH   = 2;
    localparam int unsigned MEM_MEMREAD  = 1;
    localparam int unsigned MEM_MEMWRITE = 0;
    localparam int unsigned EX_REGDST    = 3;
    localparam int unsigned EX_ALUOP_LO  = 1;
    localparam int unsigned EX_ALUSRC    = 0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10
    } aluop_e;

endpackage

// File: rtl/id_ctrl_pipe_decode_rom.sv
// Combinational opcode decoder producing the WB/MEM/EX control bundles.
module ctrl_decode_rom
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter bit          EN_ADDI  = 1'b1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [WB_W-1:0]     wb,
    output logic [MEM_W-1:0]    mem,
    output logic [EX_W-1:0]     ex,
    output logic                uses_rt,
    output logic                illegal
);

    // Table lookup; unknown opcodes fall through to an all-zero bundle flagged illegal.
    always_comb begin
        wb      = '0;
        mem     = '0;
        ex      = '0;
        uses_rt = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPCODE_W'(OP_RTYPE): begin
                wb[WB_REGWRITE]         = 1'b1;
                ex[EX_REGDST]           = 1'b1;
                ex[EX_ALUOP_LO +: 2]    = ALUOP_RTYPE;
                uses_rt                 = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
                wb[WB_REGWRITE]         = 1'b1;
                wb[WB_MEMTOREG]         = 1'b1;
                mem[MEM_MEMREAD]        = 1'b1;
                ex[EX_ALUSRC]           = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
                mem[MEM_MEMWRITE]       = 1'b1;
                ex[EX_ALUSRC]           = 1'b1;
                uses_rt                 = 1'b1;
            end
            OPCODE_W'(OP_BEQ): begin
                mem[MEM_BRANCH]         = 1'b1;
                ex[EX_ALUOP_LO +: 2]    = ALUOP_SUB;
                uses_rt                 = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
                if (EN_ADDI) begin
                    wb[WB_REGWRITE]     = 1'b1;
                    ex[EX_ALUSRC]       = 1'b1;
                end else begin
                    illegal             = 1'b1;
                end
            end
            OPCODE_W'(OP_NOP): begin
                illegal                 = 1'b0;
            end
            default: begin
                illegal                 = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ctrl_pipe.sv
// Decode-stage control generator: decodes IF/ID, detects load-use hazards and
// registers the control bundles into the ID/EX slice.
module id_ctrl_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned CNT_W    = 16,
    parameter bit          EN_ADDI  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    ex_rt,
    input  logic                flush,
    output logic [WB_W-1:0]     wb,
    output logic [MEM_W-1:0]    mem,
    output logic [EX_W-1:0]     ex,
    output logic                ctrl_valid,
    output logic                hazard_stall,
    output logic                illegal_flag,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    illegal_count
);

    logic [WB_W-1:0]  dec_wb;
    logic [MEM_W-1:0] dec_mem;
    logic [EX_W-1:0]  dec_ex;
    logic             dec_uses_rt;
    logic             dec_illegal;

    logic [WB_W-1:0]  wb_q,  wb_d;
    logic [MEM_W-1:0] mem_q, mem_d;
    logic [EX_W-1:0]  ex_q,  ex_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic             hazard;

    ctrl_decode_rom #(
        .OPCODE_W (OPCODE_W),
        .EN_ADDI  (EN_ADDI)
    ) u_rom (
        .opcode  (opcode),
        .wb      (dec_wb),
        .mem     (dec_mem),
        .ex      (dec_ex),
        .uses_rt (dec_uses_rt),
        .illegal (dec_illegal)
    );

    // Load-use detection: a load in ID/EX whose destination feeds the ID instruction.
    always_comb begin
        hazard = valid_q && mem_q[MEM_MEMREAD] && (ex_rt != '0) && in_valid &&
                 ((ex_rt == id_rs) || (dec_uses_rt && (ex_rt == id_rt)));
    end

    // Next ID/EX slice contents and counter updates, in flush > stall > idle > decode priority.
    always_comb begin
        wb_d          = '0;
        mem_d         = '0;
        ex_d          = '0;
        valid_d       = 1'b0;
        illegal_d     = illegal_q;
        stall_cnt_d   = stall_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (hazard) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (in_valid) begin
            wb_d    = dec_wb;
            mem_d   = dec_mem;
            ex_d    = dec_ex;
            valid_d = 1'b1;
            if (dec_illegal) begin
                illegal_d = 1'b1;
                if (illegal_cnt_q != '1) begin
                    illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // ID/EX control register, sticky flag and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q          <= '0;
            mem_q         <= '0;
            ex_q          <= '0;
            valid_q       <= 1'b0;
            illegal_q     <= 1'b0;
            stall_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            wb_q          <= wb_d;
            mem_q         <= mem_d;
            ex_q          <= ex_d;
            valid_q       <= valid_d;
            illegal_q     <= illegal_d;
            stall_cnt_q   <= stall_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign wb            = wb_q;
    assign mem           = mem_q;
    assign ex            = ex_q;
    assign ctrl_valid    = valid_q;
    assign hazard_stall  = hazard;
    assign illegal_flag  = illegal_q;
    assign stall_count   = stall_cnt_q;
    assign illegal_count = illegal_cnt_q;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Bench for id_ctrl_pipe: a default instance and a (CNT_W=2, EN_ADDI=0) instance
// share stimulus and are checked against a behavioural model every cycle.
module tb_id_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [5:0] opcode;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       flush;

    logic [1:0]  wb0, wb1;
    logic [2:0]  mem0, mem1;
    logic [3:0]  ex0, ex1;
    logic        cv0, cv1, hz0, hz1, il0, il1;
    logic [15:0] sc0, ic0;
    logic [1:0]  sc1, ic1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ctrl_pipe #(.OPCODE_W(6), .REG_W(5), .CNT_W(16), .EN_ADDI(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .id_rs(id_rs),
        .id_rt(id_rt), .ex_rt(ex_rt), .flush(flush), .wb(wb0), .mem(mem0), .ex(ex0),
        .ctrl_valid(cv0), .hazard_stall(hz0), .illegal_flag(il0),
        .stall_count(sc0), .illegal_count(ic0));

    id_ctrl_pipe #(.OPCODE_W(6), .REG_W(5), .CNT_W(2), .EN_ADDI(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .id_rs(id_rs),
        .id_rt(id_rt), .ex_rt(ex_rt), .flush(flush), .wb(wb1), .mem(mem1), .ex(ex1),
        .ctrl_valid(cv1), .hazard_stall(hz1), .illegal_flag(il1),
        .stall_count(sc1), .illegal_count(ic1));

    // ---------------- behavioural model ----------------
    logic [1:0] m_wb  [2];
    logic [2:0] m_mem [2];
    logic [3:0] m_ex  [2];
    logic       m_cv  [2];
    logic       m_il  [2];
    int         m_sc  [2];
    int         m_ic  [2];
    int         m_max [2] = '{65535, 3};
    bit         m_addi[2] = '{1'b1, 1'b0};

    // returns {illegal, uses_rt, wb[1:0], mem[2:0], ex[3:0]}
    function automatic logic [10:0] m_decode(input logic [5:0] op, input bit addi_on);
        case (op)
            6'b000000: return {1'b0, 1'b1, 2'b10, 3'b000, 4'b1100};
            6'b100011: return {1'b0, 1'b0, 2'b11, 3'b010, 4'b0001};
            6'b101011: return {1'b0, 1'b1, 2'b00, 3'b001, 4'b0001};
            6'b000100: return {1'b0, 1'b1, 2'b00, 3'b100, 4'b0010};
            6'b001000: return addi_on ? {1'b0, 1'b0, 2'b10, 3'b000, 4'b0001}
                                      : {1'b1, 1'b0, 9'b0};
            6'b100000: return 11'b0;
            default:   return {1'b1, 10'b0};
        endcase
    endfunction

    function automatic logic m_hazard(input int k);
        logic [10:0] d;
        d = m_decode(opcode, m_addi[k]);
        return m_cv[k] && m_mem[k][1] && (ex_rt != 0) && in_valid &&
               ((ex_rt == id_rs) || (d[9] && ex_rt == id_rt));
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_wb[k] <= 0; m_mem[k] <= 0; m_ex[k] <= 0; m_cv[k] <= 0;
                m_il[k] <= 0; m_sc[k] <= 0; m_ic[k] <= 0;
            end else if (flush || m_hazard(k) || !in_valid) begin
                m_wb[k] <= 0; m_mem[k] <= 0; m_ex[k] <= 0; m_cv[k] <= 0;
                if (!flush && m_hazard(k) && m_sc[k] < m_max[k]) m_sc[k] <= m_sc[k] + 1;
            end else begin
                logic [10:0] d;
                d = m_decode(opcode, m_addi[k]);
                m_wb[k] <= d[8:7]; m_mem[k] <= d[6:4]; m_ex[k] <= d[3:0]; m_cv[k] <= 1'b1;
                if (d[10]) begin
                    m_il[k] <= 1'b1;
                    if (m_ic[k] < m_max[k]) m_ic[k] <= m_ic[k] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("dut0.wb",  int'(wb0),  int'(m_wb[0]));
        check("dut0.mem", int'(mem0), int'(m_mem[0]));
        check("dut0.ex",  int'(ex0),  int'(m_ex[0]));
        check("dut0.cv",  int'(cv0),  int'(m_cv[0]));
        check("dut0.hz",  int'(hz0),  int'(m_hazard(0)));
        check("dut0.il",  int'(il0),  int'(m_il[0]));
        check("dut0.sc",  int'(sc0),  m_sc[0]);
        check("dut0.ic",  int'(ic0),  m_ic[0]);
        check("dut1.wb",  int'(wb1),  int'(m_wb[1]));
        check("dut1.mem", int'(mem1), int'(m_mem[1]));
        check("dut1.ex",  int'(ex1),  int'(m_ex[1]));
        check("dut1.cv",  int'(cv1),  int'(m_cv[1]));
        check("dut1.hz",  int'(hz1),  int'(m_hazard(1)));
        check("dut1.il",  int'(il1),  int'(m_il[1]));
        check("dut1.sc",  int'(sc1),  m_sc[1]);
        check("dut1.ic",  int'(ic1),  m_ic[1]);
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input logic v, input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] ert, input logic fl);
        in_valid = v; opcode = op; id_rs = rs; id_rt = rt; ex_rt = ert; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] ert, input logic fl);
        set_in(v, op, rs, rt, ert, fl);
        tick();
    endtask

    task automatic bundle(input string name, input logic [1:0] w, input logic [2:0] m,
                          input logic [3:0] e, input logic v);
        check({name, ".wb"},  int'(wb0),  int'(w));
        check({name, ".mem"}, int'(mem0), int'(m));
        check({name, ".ex"},  int'(ex0),  int'(e));
        check({name, ".cv"},  int'(cv0),  int'(v));
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 6'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        bundle("reset", 2'b00, 3'b000, 4'b0000, 1'b0);
        check("reset.sc", int'(sc0), 0);
        #6 rst = 1'b0;   // release away from a clock edge

        // decode sweep
        drive(1'b1, 6'b100011, 5'd0, 5'd0, 5'd0, 1'b0);
        bundle("lw", 2'b11, 3'b010, 4'b0001, 1'b1);
        drive(1'b1, 6'b101011, 5'd0, 5'd0, 5'd0, 1'b0);
        bundle("sw", 2'b00, 3'b001, 4'b0001, 1'b1);
        drive(1'b1, 6'b000100, 5'd0, 5'd0, 5'd0, 1'b0);
        bundle("beq", 2'b00, 3'b100, 4'b0010, 1'b1);
        drive(1'b1, 6'b001000, 5'd0, 5'd0, 5'd0, 1'b0);
        bundle("addi", 2'b10, 3'b000, 4'b0001, 1'b1);
        check("addi.dut1_il", int'(il1), 1);
        check("addi.dut1_ic", int'(ic1), 1);
        check("addi.dut1_cv", int'(cv1), 1);
        drive(1'b1, 6'b100000, 5'd0, 5'd0, 5'd0, 1'b0);
        bundle("nop", 2'b00, 3'b000, 4'b0000, 1'b1);
        check("sweep.il", int'(il0), 0);

        // asynchronous reset between edges while LW is registered
        drive(1'b1, 6'b100011, 5'd0, 5'd0, 5'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        bundle("async_rst", 2'b00, 3'b000, 4'b0000, 1'b0);
        check("async_rst.dut1_il", int'(il1), 0);
        check("async_rst.dut1_ic", int'(ic1), 0);
        #3 rst = 1'b0;
        drive(1'b1, 6'b000000, 5'd0, 5'd0, 5'd0, 1'b0);
        bundle("post_rst_rtype", 2'b10, 3'b000, 4'b1100, 1'b1);

        // load-use hazard on rt
        drive(1'b1, 6'b100011, 5'd0, 5'd0, 5'd0, 1'b0);
        set_in(1'b1, 6'b000000, 5'd1, 5'd5, 5'd5, 1'b0);
        #2;
        check("lu.hz", int'(hz0), 1);
        tick();
        bundle("lu.bubble", 2'b00, 3'b000, 4'b0000, 1'b0);
        check("lu.sc", int'(sc0), 1);
        check("lu.hz_clear", int'(hz0), 0);
        tick();
        bundle("lu.redecode", 2'b10, 3'b000, 4'b1100, 1'b1);

        // same sequence with ex_rt = 0: no stall
        drive(1'b1, 6'b100011, 5'd0, 5'd0, 5'd0, 1'b0);
        set_in(1'b1, 6'b000000, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        check("lu0.hz", int'(hz0), 0);
        tick();
        bundle("lu0.rtype", 2'b10, 3'b000, 4'b1100, 1'b1);
        check("lu0.sc", int'(sc0), 1);

        // flush beats a pending hazard
        drive(1'b1, 6'b100011, 5'd0, 5'd0, 5'd0, 1'b0);
        set_in(1'b1, 6'b000000, 5'd5, 5'd5, 5'd5, 1'b1);
        #2;
        check("flush.hz", int'(hz0), 1);
        tick();
        bundle("flush", 2'b00, 3'b000, 4'b0000, 1'b0);
        check("flush.sc", int'(sc0), 1);

        // illegal opcode
        drive(1'b1, 6'b111111, 5'd0, 5'd0, 5'd0, 1'b0);
        bundle("illegal", 2'b00, 3'b000, 4'b0000, 1'b1);
        check("illegal.il", int'(il0), 1);
        check("illegal.ic", int'(ic0), 1);
        drive(1'b1, 6'b001000, 5'd0, 5'd0, 5'd0, 1'b0);
        check("addi_off.dut1_ic", int'(ic1), 2);
        check("addi_on.dut0_ic", int'(ic0), 1);

        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) drive(1'b1, 6'b111111, 5'd0, 5'd0, 5'd0, 1'b0);
        check("sat.dut1_ic", int'(ic1), 3);
        check("sat.dut0_ic", int'(ic0), 6);

        // idle slot
        drive(1'b0, 6'b100011, 5'd0, 5'd0, 5'd0, 1'b0);
        bundle("idle", 2'b00, 3'b000, 4'b0000, 1'b0);
        check("idle.il_sticky", int'(il0), 1);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
